chasy_param: RTL and testbench

Parametrised digital-clock core, the next generation of the `chasy` top. It keeps time as HH:MM:SS (24 h) from a free-running clock prescaler and debounces the four pushbuttons itself. It adds a settable alarm with enable and ring indication, and blinks the field currently being edited. It sits directly under the board top, driving six seven-segment digits and the LED bank.

---
 rtl/chasy_param.sv | 252 +++++++++++++++++++++++++
 tb/tb_chasy_param.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/chasy_param.sv
// Parametrised 24 h digital clock core: HH:MM:SS timekeeping, alarm, button
// debouncing and six-digit seven-segment display with field blinking.
module chasy_param #(
  parameter int unsigned CLK_HZ         = 50_000_000,
  parameter int unsigned DEBOUNCE_CYC   = 1_000_000,
  parameter int unsigned SEG_ACTIVE_LOW = 1,
  parameter int unsigned LED_W          = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [0:3]       button,
  output logic [6:0]       ssegment0,
  output logic [6:0]       ssegment1,
  output logic [6:0]       ssegment2,
  output logic [6:0]       ssegment3,
  output logic [6:0]       ssegment4,
  output logic [6:0]       ssegment5,
  output logic [LED_W-1:0] led
);

  localparam int unsigned PW = $clog2(CLK_HZ);
  localparam int unsigned DW = $clog2(DEBOUNCE_CYC + 1);

  localparam logic [2:0] RUN    = 3'd0;
  localparam logic [2:0] SET_HH = 3'd1;
  localparam logic [2:0] SET_MM = 3'd2;
  localparam logic [2:0] AL_HH  = 3'd3;
  localparam logic [2:0] AL_MM  = 3'd4;

  localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  logic [3:0]    sync1, sync2, deb, deb_d, ev;
  logic [DW-1:0] cnt [4];

  logic [2:0]    mode, mode_n;
  logic [PW-1:0] presc, presc_n;
  logic [4:0]    hh, hh_n, ahh, ahh_n;
  logic [5:0]    mm, mm_n, ss, ss_n, amm, amm_n;
  logic          en, en_n, ring, ring_n;

  logic          mode_ev_c, inc_c, dec_c, al_ev_c, setting_c, tick_c, blink_c, show_al_c;
  logic [4:0]    d_hh_c;
  logic [5:0]    d_mm_c;
  logic [6:0]    seg_c [6];
  logic [LED_W-1:0] led_c;

  // Synchroniser, stability counter and falling-edge event per button
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 4'hF;
      sync2 <= 4'hF;
      deb   <= 4'hF;
      deb_d <= 4'hF;
      ev    <= 4'h0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        sync1[i] <= button[i];
        sync2[i] <= sync1[i];
        if (sync2[i] != deb[i]) begin
          if (cnt[i] == DW'(DEBOUNCE_CYC - 1)) begin
            deb[i] <= sync2[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          cnt[i] <= '0;
        end
        deb_d[i] <= deb[i];
        ev[i]    <= deb_d[i] & ~deb[i];
      end
    end
  end

  function automatic logic [5:0] wrap_step(input logic [5:0] v, input logic [5:0] maxv,
                                           input logic up);
    if (up) return (v == maxv) ? 6'd0 : v + 6'd1;
    else    return (v == 6'd0) ? maxv : v - 6'd1;
  endfunction

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      mode  <= RUN;
      presc <= '0;
      hh    <= '0;
      mm    <= '0;
      ss    <= '0;
      ahh   <= '0;
      amm   <= '0;
      en    <= 1'b0;
      ring  <= 1'b0;
    end else begin
      mode  <= mode_n;
      presc <= presc_n;
      hh    <= hh_n;
      mm    <= mm_n;
      ss    <= ss_n;
      ahh   <= ahh_n;
      amm   <= amm_n;
      en    <= en_n;
      ring  <= ring_n;
    end
  end

  // Next-state: mode sequencing, timekeeping, field edits and alarm
  always_comb begin
    mode_n = mode;
    hh_n   = hh;
    mm_n   = mm;
    ss_n   = ss;
    ahh_n  = ahh;
    amm_n  = amm;
    en_n   = en;
    ring_n = ring;

    mode_ev_c = ev[0];
    inc_c     = ev[1] & ~ev[2] & ~mode_ev_c;
    dec_c     = ev[2] & ~ev[1] & ~mode_ev_c;
    al_ev_c   = ev[3];
    setting_c = (mode == SET_HH) || (mode == SET_MM);

    // Prescaler keeps running while setting so the blink phase advances; only the tick is gated
    presc_n = (presc == PW'(CLK_HZ - 1)) ? '0 : presc + 1'b1;
    tick_c  = (presc == PW'(CLK_HZ - 1)) && !setting_c;

    if (tick_c) begin
      if (ss == 6'd59) begin
        ss_n = '0;
        if (mm == 6'd59) begin
          mm_n = '0;
          hh_n = (hh == 5'd23) ? 5'd0 : hh + 5'd1;
        end else begin
          mm_n = mm + 6'd1;
        end
      end else begin
        ss_n = ss + 6'd1;
      end
    end

    if (inc_c || dec_c) begin
      case (mode)
        SET_HH:  hh_n  = 5'(wrap_step(6'(hh), 6'd23, inc_c));
        SET_MM:  mm_n  = wrap_step(mm, 6'd59, inc_c);
        AL_HH:   ahh_n = 5'(wrap_step(6'(ahh), 6'd23, inc_c));
        AL_MM:   amm_n = wrap_step(amm, 6'd59, inc_c);
        default: ;
      endcase
    end

    if (mode_ev_c) begin
      case (mode)
        RUN:    mode_n = SET_HH;
        SET_HH: mode_n = SET_MM;
        SET_MM: begin
          mode_n  = AL_HH;
          ss_n    = '0;
          presc_n = '0;
        end
        AL_HH:   mode_n = AL_MM;
        default: mode_n = RUN;
      endcase
    end

    if (tick_c && ss_n == 6'd0)
      ring_n = en && (hh_n == ahh) && (mm_n == amm);

    if (al_ev_c) begin
      if (ring) ring_n = 1'b0;
      else      en_n   = ~en;
    end
    if (!en_n) ring_n = 1'b0;
  end

  function automatic logic [6:0] seg_pat(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'h40;
      4'd1:    p = 7'h79;
      4'd2:    p = 7'h24;
      4'd3:    p = 7'h30;
      4'd4:    p = 7'h19;
      4'd5:    p = 7'h12;
      4'd6:    p = 7'h02;
      4'd7:    p = 7'h78;
      4'd8:    p = 7'h00;
      4'd9:    p = 7'h10;
      default: p = 7'h7F;
    endcase
    return (SEG_ACTIVE_LOW != 0) ? p : ~p;
  endfunction

  function automatic logic [3:0] tens(input logic [5:0] v);
    return 4'(v / 6'd10);
  endfunction

  function automatic logic [3:0] units(input logic [5:0] v);
    return 4'(v % 6'd10);
  endfunction

  // Display and LED decode from the current state
  always_comb begin
    blink_c   = (presc >= PW'(CLK_HZ / 2));
    show_al_c = (mode == AL_HH) || (mode == AL_MM);
    d_hh_c    = show_al_c ? ahh : hh;
    d_mm_c    = show_al_c ? amm : mm;

    seg_c[5] = seg_pat(tens(6'(d_hh_c)));
    seg_c[4] = seg_pat(units(6'(d_hh_c)));
    seg_c[3] = seg_pat(tens(d_mm_c));
    seg_c[2] = seg_pat(units(d_mm_c));
    seg_c[1] = show_al_c ? SEG_OFF : seg_pat(tens(ss));
    seg_c[0] = show_al_c ? SEG_OFF : seg_pat(units(ss));

    if (blink_c && (mode == SET_HH || mode == AL_HH)) begin
      seg_c[5] = SEG_OFF;
      seg_c[4] = SEG_OFF;
    end
    if (blink_c && (mode == SET_MM || mode == AL_MM)) begin
      seg_c[3] = SEG_OFF;
      seg_c[2] = SEG_OFF;
    end

    led_c      = '0;
    led_c[0]   = en;
    led_c[1]   = ring;
    led_c[6:2] = 5'b00001 << mode;
  end

  // Output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      ssegment0 <= seg_pat(4'd0);
      ssegment1 <= seg_pat(4'd0);
      ssegment2 <= seg_pat(4'd0);
      ssegment3 <= seg_pat(4'd0);
      ssegment4 <= seg_pat(4'd0);
      ssegment5 <= seg_pat(4'd0);
      led       <= LED_W'(4);
    end else begin
      ssegment0 <= seg_c[0];
      ssegment1 <= seg_c[1];
      ssegment2 <= seg_c[2];
      ssegment3 <= seg_c[3];
      ssegment4 <= seg_c[4];
      ssegment5 <= seg_c[5];
      led       <= led_c;
    end
  end

endmodule

// File: tb/tb_chasy_param.sv
// Directed bench for chasy_param with CLK_HZ=10, DEBOUNCE_CYC=4, active-low segments.
module tb_chasy_param;

  localparam logic [3:0] B_MODE = 4'b0001;
  localparam logic [3:0] B_INC  = 4'b0010;
  localparam logic [3:0] B_DEC  = 4'b0100;
  localparam logic [3:0] B_AL   = 4'b1000;

  localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30;
  localparam logic [6:0] S5 = 7'h12, S9 = 7'h10, SOFF = 7'h7F;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [0:3] button = 4'hF;
  logic [6:0] ssegment0, ssegment1, ssegment2, ssegment3, ssegment4, ssegment5;
  logic [9:0] led;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  chasy_param #(
    .CLK_HZ(10), .DEBOUNCE_CYC(4), .SEG_ACTIVE_LOW(1), .LED_W(10)
  ) dut (
    .clock(clock), .reset(reset), .button(button),
    .ssegment0(ssegment0), .ssegment1(ssegment1), .ssegment2(ssegment2),
    .ssegment3(ssegment3), .ssegment4(ssegment4), .ssegment5(ssegment5),
    .led(led)
  );

  always #5 clock = ~clock;

  // Cycles since reset release; equals the DUT prescaler until set mode is first left
  always @(posedge clock) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [3:0] mask);
    for (int i = 0; i < 4; i++) if (mask[i]) button[i] = 1'b0;
    step(10);
    button = 4'hF;
    step(10);
  endtask

  // Advance to a point where the set-mode blink phase is off for this and the next few cycles
  task automatic vis();
    int k;
    k = 0;
    while (!((cyc % 10) >= 1 && (cyc % 10) <= 5) && k < 12) begin
      step(1);
      k++;
    end
  endtask

  task automatic step_to(input int m);
    int k;
    k = 0;
    while ((cyc % 10) != m && k < 12) begin
      step(1);
      k++;
    end
  endtask

  task automatic chk_all(input string tag, input logic [6:0] h1, input logic [6:0] h0,
                         input logic [6:0] m1, input logic [6:0] m0,
                         input logic [6:0] s1, input logic [6:0] s0);
    chk({tag, "_seg5"}, 32'(ssegment5), 32'(h1));
    chk({tag, "_seg4"}, 32'(ssegment4), 32'(h0));
    chk({tag, "_seg3"}, 32'(ssegment3), 32'(m1));
    chk({tag, "_seg2"}, 32'(ssegment2), 32'(m0));
    chk({tag, "_seg1"}, 32'(ssegment1), 32'(s1));
    chk({tag, "_seg0"}, 32'(ssegment0), 32'(s0));
  endtask

  initial begin
    // Reset state and first second
    step(3);
    chk_all("reset", S0, S0, S0, S0, S0, S0);
    chk("reset_led", 32'(led), 32'h004);
    reset = 1'b0;
    step(10);
    chk("pre_tick_seg0", 32'(ssegment0), 32'(S0));
    step(1);
    chk("tick_seg0", 32'(ssegment0), 32'(S1));

    // Enter SET_HH; time frozen at 00:00:01
    press(B_MODE);
    chk("set_hh_led", 32'(led), 32'h008);

    // Short glitch on inc is ignored
    button[1] = 1'b0;
    step(2);
    button = 4'hF;
    step(10);
    vis();
    chk("glitch_seg5", 32'(ssegment5), 32'(S0));
    chk("glitch_seg4", 32'(ssegment4), 32'(S0));

    // Blink: hours blanked in the second half of the second, other digits stay lit
    step_to(7);
    chk("blink_seg5", 32'(ssegment5), 32'(SOFF));
    chk("blink_seg4", 32'(ssegment4), 32'(SOFF));
    chk("blink_seg3", 32'(ssegment3), 32'(S0));
    chk("blink_seg0", 32'(ssegment0), 32'(S1));
    step_to(2);
    chk("unblink_seg5", 32'(ssegment5), 32'(S0));

    // One inc press: segment changes DEBOUNCE_CYC+5 edges after the raw edge
    step_to(3);
    button[1] = 1'b0;
    step(8);
    chk("inc_lat_before", 32'(ssegment4), 32'(S0));
    step(1);
    chk("inc_lat_after", 32'(ssegment4), 32'(S1));
    step(1);
    button = 4'hF;
    step(10);
    vis();
    chk("inc_once_seg4", 32'(ssegment4), 32'(S1));
    chk("inc_once_seg5", 32'(ssegment5), 32'(S0));

    repeat (22) press(B_INC);
    vis();
    chk("hh23_seg5", 32'(ssegment5), 32'(S2));
    chk("hh23_seg4", 32'(ssegment4), 32'(S3));

    // Mode with inc: mode advances, hours untouched
    press(B_MODE | B_INC);
    chk("mode_inc_led", 32'(led), 32'h010);
    chk("mode_inc_seg5", 32'(ssegment5), 32'(S2));
    chk("mode_inc_seg4", 32'(ssegment4), 32'(S3));

    // inc+dec together leaves minutes alone, then dec wraps 0 -> 59
    press(B_INC | B_DEC);
    vis();
    chk("incdec_seg3", 32'(ssegment3), 32'(S0));
    chk("incdec_seg2", 32'(ssegment2), 32'(S0));
    press(B_DEC);
    vis();
    chk("mm59_seg3", 32'(ssegment3), 32'(S5));
    chk("mm59_seg2", 32'(ssegment2), 32'(S9));

    // Leave SET_MM (ss and prescaler cleared), pass through alarm modes back to RUN: 23:59:05
    press(B_MODE);
    press(B_MODE);
    press(B_MODE);
    chk("run_led", 32'(led), 32'h004);
    chk_all("run", S2, S3, S5, S9, S0, S5);
    step(548);
    chk("pre_wrap_seg0", 32'(ssegment0), 32'(S9));
    step(1);
    chk_all("wrap", S0, S0, S0, S0, S0, S0);

    // Alarm at 00:01 with time restarted at 00:00:00
    press(B_MODE);
    press(B_MODE);
    press(B_MODE);
    chk("al_hh_led", 32'(led), 32'h020);
    press(B_MODE);
    press(B_INC);
    press(B_MODE);
    press(B_AL);
    chk("al_en_led", 32'(led), 32'h005);
    step(508);
    chk("pre_ring_led", 32'(led), 32'h005);
    step(1);
    chk("ring_led", 32'(led), 32'h007);
    chk("ring_mm_seg2", 32'(ssegment2), 32'(S1));
    step(598);
    chk("ring_hold_led", 32'(led), 32'h007);
    step(2);
    chk("ring_auto_clear", 32'(led), 32'h005);

    // Alarm at 00:03 from 00:02:00, acknowledged by the alarm button
    press(B_MODE);
    press(B_MODE);
    press(B_MODE);
    press(B_MODE);
    press(B_INC);
    press(B_INC);
    press(B_MODE);
    step(509);
    chk("ring2_led", 32'(led), 32'h007);
    press(B_AL);
    chk("ack_led", 32'(led), 32'h005);
    press(B_AL);
    chk("disable_led", 32'(led), 32'h004);

    // Reset in the middle of SET_MM
    press(B_MODE);
    press(B_MODE);
    press(B_INC);
    reset = 1'b1;
    step(1);
    chk("midreset_led", 32'(led), 32'h004);
    chk_all("midreset", S0, S0, S0, S0, S0, S0);
    reset = 1'b0;
    step(2);
    chk("after_reset_led", 32'(led), 32'h004);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
